// File: rtl/axi_burst_mem_pkg.sv
// Shared constants, FSM state types and burst helpers for the axi_burst_mem slave.
package axi_burst_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Only power-of-two beat counts of 2..16 form a legal wrap window.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_mem_addr_gen.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts of 4-byte beats.
module axi_burst_mem_addr_gen
  import axi_burst_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr_i + ADDR_W'(4);
    // (len+1)*4-1 equals {len, 2'b11} for every legal wrap length
    wrap_mask = ADDR_W'({len_i, 2'b11});
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP:  next_addr_o = wrap_len_ok(len_i)
                                 ? ((addr_i & ~wrap_mask) | (incr_addr & wrap_mask))
                                 : incr_addr;
      default:     next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 burst memory slave with independent write and read engines over a word array.
// Optional `AXI_MEM_RANGE_CHECK_EN: out-of-range beats are dropped/zeroed and answered with SLVERR.
module axi_burst_mem
  import axi_burst_mem_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output w_state_t                    dbg_w_state_o,
  output r_state_t                    dbg_r_state_o
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
  // a source never withdraws VALID or changes its payload until that edge.

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_t                  w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next_addr;
  logic [7:0]                w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]                w_burst_q, w_burst_d;
  logic                      w_err_q, w_err_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      w_mem_we, w_last_beat, w_beat_err, w_beat_oor;

  r_state_t                  r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr, r_load_addr;
  logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]                r_burst_q, r_burst_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      r_load, r_beat_oor;

  logic unused_size;
  assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

  axi_burst_mem_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .len_i       (w_len_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next_addr)
  );

  axi_burst_mem_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_r_addr_gen (
    .addr_i      (r_addr_q),
    .len_i       (r_len_q),
    .burst_i     (r_burst_q),
    .next_addr_o (r_next_addr)
  );

  // The read word fetched this edge: the burst start in idle, otherwise the following beat.
  always_comb begin
    r_load_addr = (r_state_q == R_IDLE) ? S_AXI_ARADDR : r_next_addr;
  end

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(MEM_DEPTH * 4);
  assign w_beat_oor = (w_addr_q >= ADDR_LIMIT);
  assign r_beat_oor = (r_load_addr >= ADDR_LIMIT);
`else
  assign w_beat_oor = 1'b0;
  assign r_beat_oor = 1'b0;
`endif

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    w_mem_we    = 1'b0;
    w_beat_err  = 1'b0;
    w_last_beat = (w_cnt_q == w_len_q);
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          w_id_d    = S_AXI_AWID;
          w_addr_d  = S_AXI_AWADDR;
          w_len_d   = S_AXI_AWLEN;
          w_burst_d = S_AXI_AWBURST;
          w_cnt_d   = 8'd0;
          w_err_d   = (S_AXI_AWBURST == BURST_RSVD);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          w_beat_err = (S_AXI_WLAST != w_last_beat) || w_beat_oor;
          w_mem_we   = !w_beat_oor;
          w_addr_d   = w_next_addr;
          w_cnt_d    = w_cnt_q + 8'd1;
          w_err_d    = w_err_q || w_beat_err;
          // An early WLAST closes the burst on the spot.
          if (w_last_beat || S_AXI_WLAST) begin
            w_state_d = W_RESP;
            bid_d     = w_id_q;
            bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          r_addr_d  = S_AXI_ARADDR;
          r_len_d   = S_AXI_ARLEN;
          r_burst_d = S_AXI_ARBURST;
          r_cnt_d   = 8'd0;
          rid_d     = S_AXI_ARID;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
            r_load   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Reads sample the array before this edge's write lands, so a collision returns old data.
    if (r_load) begin
      rdata_d = r_beat_oor ? '0 : mem_q[r_load_addr[2 +: IDX_W]];
      rresp_d = r_beat_oor ? RESP_SLVERR : RESP_OKAY;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Memory has no reset; a beat presented during reset is discarded.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_mem_we && !S_AXI_ARESET) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem_q[w_addr_q[2 +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: single-beat vector table plus burst, stall, error and reset sequences.
module tb_axi_burst_mem;
  import axi_burst_mem_pkg::*;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        awid, wlast, awvalid, awready, wvalid, wready, bid, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        arid, arvalid, arready, rid, rlast, rvalid, rready;
  w_state_t    dbg_w;
  r_state_t    dbg_r;

  initial forever #5 clk = ~clk;

  axi_burst_mem dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .dbg_w_state_o(dbg_w), .dbg_r_state_o(dbg_r)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wbuf[256];
  logic [3:0]  sbuf[256];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] exp;
    logic        id;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_timeout(input string name);
    n_total++;
    $display("FAIL %s: got no handshake expected one within %0d cycles", name, TMO);
  endtask

  // Called and returns at #1 after a rising edge; beats 0..last_at are sent, WLAST on last_at.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic id, input int last_at,
                           output logic [1:0] resp, output logic rid_o);
    int t;
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = 3'b010; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) note_timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_at); wvalid = 1'b1;
      t = 0;
      while (!wready && t < TMO) begin @(posedge clk); #1; t++; end
      if (t >= TMO) note_timeout("w_handshake");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) note_timeout("b_handshake");
    resp = bresp; rid_o = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Pops one expected word per accepted beat; with stall, RREADY follows 1,0,0,1 per cycle.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic id, input bit stall, input logic [1:0] exp_resp,
                          input string tag);
    int          t, beat, cyc;
    logic        held, held_last;
    logic [31:0] held_data, exp;
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = 3'b010; arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin @(posedge clk); #1; t++; end
    if (t >= TMO) note_timeout({tag, "_ar"});
    @(posedge clk); #1;
    arvalid = 1'b0;
    beat = 0; cyc = 0; held = 1'b0; held_last = 1'b0; held_data = '0;
    while (beat <= len && cyc < TMO) begin
      rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (held) begin
        check({tag, "_stall_data"}, rdata, held_data);
        check({tag, "_stall_last"}, {31'd0, rlast}, {31'd0, held_last});
        held = 1'b0;
      end
      if (rvalid) begin
        if (rready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
          check($sformatf("%s_data%0d", tag, beat), rdata, exp);
          check($sformatf("%s_last%0d", tag, beat), {31'd0, rlast}, {31'd0, (beat == len)});
          check($sformatf("%s_resp%0d", tag, beat), {30'd0, rresp}, {30'd0, exp_resp});
          check($sformatf("%s_rid%0d", tag, beat), {31'd0, rid}, {31'd0, id});
          beat++;
        end else begin
          held = 1'b1; held_data = rdata; held_last = rlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (beat <= len) note_timeout({tag, "_r_beats"});
    check({tag, "_rvalid_drop"}, {31'd0, rvalid}, 32'd0);
  endtask

  logic [1:0] resp_w;
  logic       bid_w;

  initial begin
    rst = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = BURST_INCR; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = BURST_INCR; arvalid = 0; rready = 0;
    for (int i = 0; i < 256; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("reset_bresp_bid_rlast", {26'd0, bresp, bid, rresp, rlast}, 32'd0);
    check("reset_rdata_rid", rdata ^ {31'd0, rid}, 32'd0);
    check("reset_dbg", {29'd0, dbg_w, dbg_r}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("awready_after_rst", {31'd0, awready}, 32'd1);
    check("arready_after_rst", {31'd0, arready}, 32'd1);

    // Single-beat INCR vectors: write then read back, strobes merge with earlier contents.
    vecs[0] = '{32'h000, 32'h0000_0003, 4'hF, 32'h000, 32'h0000_0003, 1'b0};
    vecs[1] = '{32'h008, 32'hFFFF_FFFF, 4'hF, 32'h008, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h008, 32'h1234_5678, 4'h3, 32'h008, 32'hFFFF_5678, 1'b0};
    vecs[3] = '{32'h008, 32'hAABB_CCDD, 4'h8, 32'h008, 32'hAAFF_5678, 1'b1};
    vecs[4] = '{32'h00C, 32'h0BAD_BEEF, 4'hF, 32'h00C, 32'h0BAD_BEEF, 1'b0};
    vecs[5] = '{32'h00C, 32'hFFFF_FFFF, 4'h0, 32'h00C, 32'h0BAD_BEEF, 1'b1};
    vecs[6] = '{32'h3FC, 32'h5A5A_5A5A, 4'hF, 32'h3FC, 32'h5A5A_5A5A, 1'b0};
    vecs[7] = '{32'h007, 32'h1111_1111, 4'hF, 32'h004, 32'h1111_1111, 1'b1};
    vecs[8] = '{32'h005, 32'h0022_0000, 4'h4, 32'h006, 32'h1122_1111, 1'b0};
    for (int i = 0; i < 9; i++) begin
      wbuf[0] = vecs[i].wdata; sbuf[0] = vecs[i].wstrb;
      axi_write(vecs[i].waddr, 0, BURST_INCR, vecs[i].id, 0, resp_w, bid_w);
      check($sformatf("vec%0d_bresp", i), {30'd0, resp_w}, {30'd0, RESP_OKAY});
      check($sformatf("vec%0d_bid", i), {31'd0, bid_w}, {31'd0, vecs[i].id});
      exp_q.push_back(vecs[i].exp);
      axi_read(vecs[i].raddr, 0, BURST_INCR, vecs[i].id, 1'b0, RESP_OKAY, $sformatf("vec%0d", i));
    end
    sbuf[0] = 4'hF;

    // 32-beat INCR burst
    for (int i = 0; i < 32; i++) wbuf[i] = 32'h6434_3962 + 32'h0101_0001 * i;
    axi_write(32'h40, 31, BURST_INCR, 1'b1, 31, resp_w, bid_w);
    check("incr32_bresp", {30'd0, resp_w}, {30'd0, RESP_OKAY});
    check("incr32_bid", {31'd0, bid_w}, 32'd1);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'h6434_3962 + 32'h0101_0001 * i);
    axi_read(32'h40, 31, BURST_INCR, 1'b1, 1'b0, RESP_OKAY, "incr32");

    // WRAP len3 from 0x18 lands on 0x18,0x1C,0x10,0x14
    wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B; wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
    axi_write(32'h18, 3, BURST_WRAP, 1'b0, 3, resp_w, bid_w);
    check("wrap4_bresp", {30'd0, resp_w}, {30'd0, RESP_OKAY});
    exp_q.push_back(32'hCCCC_000C); exp_q.push_back(32'hDDDD_000D);
    exp_q.push_back(32'hAAAA_000A); exp_q.push_back(32'hBBBB_000B);
    axi_read(32'h10, 3, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "wrap4");

    // WRAP with len2 is not a legal wrap length and must step like INCR
    wbuf[0] = 32'hE1E1_E1E1; wbuf[1] = 32'hE2E2_E2E2; wbuf[2] = 32'hE3E3_E3E3;
    axi_write(32'h58, 2, BURST_WRAP, 1'b0, 2, resp_w, bid_w);
    exp_q.push_back(32'hE1E1_E1E1); exp_q.push_back(32'hE2E2_E2E2); exp_q.push_back(32'hE3E3_E3E3);
    axi_read(32'h58, 2, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "wrap3_as_incr");

    // FIXED write keeps the last beat; FIXED read repeats one word
    wbuf[0] = 32'h0000_0001; wbuf[1] = 32'h0000_0002; wbuf[2] = 32'h0000_0003;
    axi_write(32'h80, 2, BURST_FIXED, 1'b0, 2, resp_w, bid_w);
    exp_q.push_back(32'h0000_0003);
    axi_read(32'h80, 0, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "fixed_w");
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hAAFF_5678);
    axi_read(32'h08, 3, BURST_FIXED, 1'b1, 1'b0, RESP_OKAY, "fixed_r");

    // Reserved burst type: steps as INCR, answered SLVERR
    wbuf[0] = 32'hF1F1_0001; wbuf[1] = 32'hF2F2_0002;
    axi_write(32'h90, 1, BURST_RSVD, 1'b1, 1, resp_w, bid_w);
    check("rsvd_bresp", {30'd0, resp_w}, {30'd0, RESP_SLVERR});
    exp_q.push_back(32'hF1F1_0001); exp_q.push_back(32'hF2F2_0002);
    axi_read(32'h90, 1, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "rsvd_data");

    // Stalled read of 8 beats with a concurrent 4-beat write elsewhere
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h0100_0000 + i;
    axi_write(32'h100, 7, BURST_INCR, 1'b0, 7, resp_w, bid_w);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h0100_0000 + i);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0200_0000 + i;
    fork
      axi_read(32'h100, 7, BURST_INCR, 1'b1, 1'b1, RESP_OKAY, "stall8");
      axi_write(32'h200, 3, BURST_INCR, 1'b1, 3, resp_w, bid_w);
    join
    check("concurrent_bresp", {30'd0, resp_w}, {30'd0, RESP_OKAY});
    check("concurrent_bid", {31'd0, bid_w}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0200_0000 + i);
    axi_read(32'h200, 3, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "concurrent_data");

    // Early WLAST on the second beat of a 4-beat burst
    wbuf[0] = 32'h3000_0000; wbuf[1] = 32'h3000_0001;
    axi_write(32'h300, 3, BURST_INCR, 1'b0, 1, resp_w, bid_w);
    check("early_wlast_bresp", {30'd0, resp_w}, {30'd0, RESP_SLVERR});
    check("early_wlast_awready", {31'd0, awready}, 32'd1);
    exp_q.push_back(32'h3000_0000); exp_q.push_back(32'h3000_0001);
    axi_read(32'h300, 1, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "early_wlast_data");
    wbuf[0] = 32'h3100_0000;
    axi_write(32'h310, 0, BURST_INCR, 1'b0, 0, resp_w, bid_w);
    check("after_err_bresp", {30'd0, resp_w}, {30'd0, RESP_OKAY});

    // Reset in the middle of a write burst and a stalled read burst
    awid = 1'b0; awaddr = 32'h380; awlen = 8'd3; awburst = BURST_INCR; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    arid = 1'b1; araddr = 32'h100; arlen = 8'd7; arburst = BURST_INCR; arvalid = 1'b1; rready = 1'b0;
    wdata = 32'h3800_0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; wvalid = 1'b0;
    check("midburst_busy", {30'd0, wready, rvalid}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {30'd0, awready, arready}, 32'd3);
    check("midrst_dbg", {29'd0, dbg_w, dbg_r}, 32'd0);
    exp_q.push_back(32'h0000_0003);
    axi_read(32'h000, 0, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "post_rst");

`ifdef AXI_MEM_RANGE_CHECK_EN
    wbuf[0] = 32'hDEAD_DEAD;
    axi_write(32'h400, 0, BURST_INCR, 1'b0, 0, resp_w, bid_w);
    check("range_bresp", {30'd0, resp_w}, {30'd0, RESP_SLVERR});
    exp_q.push_back(32'h0000_0003);
    axi_read(32'h000, 0, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "range_word0");
    exp_q.push_back(32'h0000_0000);
    axi_read(32'h400, 0, BURST_INCR, 1'b0, 1'b0, RESP_SLVERR, "range_read");
`else
    wbuf[0] = 32'hDEAD_DEAD;
    axi_write(32'h400, 0, BURST_INCR, 1'b0, 0, resp_w, bid_w);
    check("alias_bresp", {30'd0, resp_w}, {30'd0, RESP_OKAY});
    exp_q.push_back(32'hDEAD_DEAD);
    axi_read(32'h000, 0, BURST_INCR, 1'b0, 1'b0, RESP_OKAY, "alias_word0");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
